boot_mem_hex_loader: RTL and testbench



---
 rtl/boot_mem_hex_loader.sv | 271 +++++++++++++++++++++++++++
 tb/tb_boot_mem_hex_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_mem_hex_loader.sv
// Streams "@AAAAAAAA DDDDDDDD" hex-image lines from a UART byte FIFO into boot-RAM word writes.
// Optional macro BOOT_LOADER_CHECKSUM_EN adds "#XXXXXXXX" running-sum check lines.
module boot_mem_hex_loader #(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 11,
  parameter int CNT_W  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rx_valid,
  input  logic [7:0]          i_rx_data,
  output logic                o_rx_ready,
  output logic                o_wr_en,
  output logic [MEM_AW-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic [DATA_W/8-1:0] o_wr_be,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
`ifdef BOOT_LOADER_CHECKSUM_EN
  output logic [31:0]         o_checksum,
  output logic                o_csum_ok,
`endif
  output logic [CNT_W-1:0]    o_line_count,
  output logic [CNT_W-1:0]    o_word_count
);

  typedef enum logic [3:0] {
    S_LINE, S_SLASH, S_ADDR, S_SEP, S_DATA, S_WRITE, S_SKIP, S_ERR, S_DONE
`ifdef BOOT_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      line_q, line_d;
  logic [CNT_W-1:0]      word_q, word_d;
  logic                  wr_en_q, wr_en_d;
  logic [MEM_AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [DATA_W/8-1:0]   wr_be_q, wr_be_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
  logic                  csum_ok_q, csum_ok_d;
`endif

  logic                  is_hex, is_ws, is_nl, take, in_record, line_inc;
  logic [3:0]            nib;
  logic [31:0]           data_word;
  logic [MEM_AW-1:0]     word_addr;
  logic [DATA_W-1:0]     word_data;
  logic [DATA_W/8-1:0]   word_be;
  logic                  unused_bits;

  always_comb begin
    is_hex = 1'b1;
    nib    = 4'h0;
    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
      nib = i_rx_data[3:0];
    end else if ((i_rx_data >= 8'h61 && i_rx_data <= 8'h66) ||
                 (i_rx_data >= 8'h41 && i_rx_data <= 8'h46)) begin
      nib = i_rx_data[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  assign is_ws      = (i_rx_data == 8'h20) || (i_rx_data == 8'h09);
  assign is_nl      = (i_rx_data == 8'h0A);
  assign o_rx_ready = (state_q != S_WRITE) && (state_q != S_DONE);
  // Carriage returns are dropped before the FSM so CRLF images parse like LF images.
  assign take       = i_rx_valid && o_rx_ready && (i_rx_data != 8'h0D);
  assign data_word  = {data_q[27:0], nib};

  always_comb begin
    in_record = (state_q == S_SLASH) || (state_q == S_ADDR) ||
                (state_q == S_SEP)   || (state_q == S_DATA);
`ifdef BOOT_LOADER_CHECKSUM_EN
    if (state_q == S_CSUM) in_record = 1'b1;
`endif
  end

  generate
    if (DATA_W == 128) begin : g_w128
      assign word_addr = addr_q[MEM_AW+3:4];
      assign word_data = {4{data_word}};
      assign word_be   = 16'h000F << {addr_q[3:2], 2'b00};
    end else begin : g_w32
      assign word_addr = addr_q[MEM_AW+1:2];
      assign word_data = data_word;
      assign word_be   = '1;
    end
  endgenerate

  // High address bits wrap silently; the top data nibble is always shifted out.
  assign unused_bits = ^{addr_q, data_q[31:28]};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    line_d    = line_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    line_inc  = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    csum_ok_d = csum_ok_q;
`endif
    if (state_q == S_WRITE) begin
      state_d = S_SKIP;
    end else if (take) begin
      if (is_nl && in_record) begin
        state_d  = S_LINE;
        err_d    = 1'b1;
        line_inc = 1'b1;
      end else begin
        case (state_q)
          S_LINE: begin
            if (i_rx_data == 8'h2F) begin
              state_d = S_SLASH;
            end else if (i_rx_data == 8'h40) begin
              state_d = S_ADDR;
              cnt_d   = 4'd0;
            end else if (is_nl) begin
              line_inc = 1'b1;
            end else if (is_ws) begin
              state_d = S_LINE;
            end else if (i_rx_data == 8'h04) begin
              state_d = S_DONE;
`ifdef BOOT_LOADER_CHECKSUM_EN
            end else if (i_rx_data == 8'h23) begin
              state_d = S_CSUM;
              cnt_d   = 4'd0;
`endif
            end else begin
              state_d = S_ERR;
            end
          end
          S_SLASH: state_d = (i_rx_data == 8'h2F) ? S_SKIP : S_ERR;
          S_ADDR: begin
            if (is_hex) begin
              addr_d = {addr_q[27:0], nib};
              if (cnt_q != 4'd9) cnt_d = cnt_q + 4'd1;
            end else if (is_ws && cnt_q == 4'd8) begin
              state_d = S_SEP;
            end else begin
              state_d = S_ERR;
            end
          end
          S_SEP: begin
            if (is_hex) begin
              data_d  = data_word;
              cnt_d   = 4'd1;
              state_d = S_DATA;
            end else if (!is_ws) begin
              state_d = S_ERR;
            end
          end
          S_DATA: begin
            if (is_hex) begin
              data_d = data_word;
              cnt_d  = cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                if (addr_q[1:0] == 2'b00) begin
                  state_d   = S_WRITE;
                  wr_en_d   = 1'b1;
                  wr_addr_d = word_addr;
                  wr_data_d = word_data;
                  wr_be_d   = word_be;
                  if (!(&word_q)) word_d = word_q + 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                  sum_d = sum_q + data_word;
`endif
                end else begin
                  state_d = S_ERR;
                end
              end
            end else begin
              state_d = S_ERR;
            end
          end
`ifdef BOOT_LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (is_hex) begin
              data_d = data_word;
              cnt_d  = cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                state_d = S_SKIP;
                if (data_word == sum_q) csum_ok_d = 1'b1;
                else                    err_d     = 1'b1;
              end
            end else begin
              state_d = S_ERR;
            end
          end
`endif
          S_SKIP, S_ERR: begin
            if (is_nl) begin
              state_d  = S_LINE;
              line_inc = 1'b1;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
    if (state_d == S_ERR) err_d = 1'b1;
    if (line_inc && !(&line_q)) line_d = line_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_LINE;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      line_q    <= '0;
      word_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      csum_ok_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      line_q    <= line_d;
      word_q    <= word_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
      csum_ok_q <= csum_ok_d;
`endif
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_wr_be      = wr_be_q;
  assign o_busy       = (state_q != S_LINE) && (state_q != S_DONE);
  assign o_done       = (state_q == S_DONE);
  assign o_err        = err_q;
  assign o_line_count = line_q;
  assign o_word_count = word_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
  assign o_checksum   = sum_q;
  assign o_csum_ok    = csum_ok_q;
`endif

endmodule

// File: tb/tb_boot_mem_hex_loader.sv
// Directed bench for boot_mem_hex_loader: a 32-bit and a 128-bit instance share one byte stream.
module tb_boot_mem_hex_loader;

  logic clk;
  logic rst_n;
  logic rx_valid;
  logic [7:0] rx_data;

  logic rdy_a, wr_en_a, busy_a, done_a, err_a;
  logic [10:0] wr_addr_a;
  logic [31:0] wr_data_a;
  logic [3:0] wr_be_a;
  logic [15:0] line_a, word_a;

  logic rdy_b, wr_en_b, busy_b, done_b, err_b;
  logic [10:0] wr_addr_b;
  logic [127:0] wr_data_b;
  logic [15:0] wr_be_b;
  logic [15:0] line_b, word_b;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] csum_a, csum_b;
  logic csum_ok_a, csum_ok_b;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  logic [10:0] last_addr_a, last_addr_b;
  logic [31:0] last_data_a;
  logic [127:0] last_data_b;
  logic [3:0] last_be_a;
  logic [15:0] last_be_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  boot_mem_hex_loader #(.DATA_W(32), .MEM_AW(11), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_rx_ready(rdy_a), .o_wr_en(wr_en_a), .o_wr_addr(wr_addr_a), .o_wr_data(wr_data_a),
    .o_wr_be(wr_be_a), .o_busy(busy_a), .o_done(done_a), .o_err(err_a),
`ifdef BOOT_LOADER_CHECKSUM_EN
    .o_checksum(csum_a), .o_csum_ok(csum_ok_a),
`endif
    .o_line_count(line_a), .o_word_count(word_a)
  );

  boot_mem_hex_loader #(.DATA_W(128), .MEM_AW(11), .CNT_W(16)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_rx_ready(rdy_b), .o_wr_en(wr_en_b), .o_wr_addr(wr_addr_b), .o_wr_data(wr_data_b),
    .o_wr_be(wr_be_b), .o_busy(busy_b), .o_done(done_b), .o_err(err_b),
`ifdef BOOT_LOADER_CHECKSUM_EN
    .o_checksum(csum_b), .o_csum_ok(csum_ok_b),
`endif
    .o_line_count(line_b), .o_word_count(word_b)
  );

  // Capture write strobes between clock edges.
  always @(negedge clk) begin
    if (wr_en_a === 1'b1) begin
      wr_cnt_a++; last_addr_a = wr_addr_a; last_data_a = wr_data_a; last_be_a = wr_be_a;
      $display("[TB] wr32  addr=%0h data=%h be=%h", wr_addr_a, wr_data_a, wr_be_a);
    end
    if (wr_en_b === 1'b1) begin
      wr_cnt_b++; last_addr_b = wr_addr_b; last_data_b = wr_data_b; last_be_b = wr_be_b;
      $display("[TB] wr128 addr=%0h data=%h be=%h", wr_addr_b, wr_data_b, wr_be_b);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    guard = 0;
    rx_valid = 1'b1; rx_data = b;
    while (rdy_a !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    if (rdy_a !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL handshake_timeout: ready=%b required 1 (byte %h)", rdy_a, b);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      if (gap > 0) begin
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    rx_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (rdy_a !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b required 1", rdy_a); end
    tests_run++; if ({wr_en_a, busy_a, done_a, err_a} !== 4'b0) begin tests_failed++; $display("FAIL reset_flags: got %b required 0000", {wr_en_a, busy_a, done_a, err_a}); end
    tests_run++; if ({line_a, word_a} !== 32'd0) begin tests_failed++; $display("FAIL reset_counts: got %h required 0", {line_a, word_a}); end
    tests_run++; if ({wr_addr_a, wr_data_a, wr_be_a} !== '0) begin tests_failed++; $display("FAIL reset_wr_bus: got %h required 0", {wr_addr_a, wr_data_a, wr_be_a}); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic();
    int c0, d0;
    do_reset(); c0 = wr_cnt_a; d0 = wr_cnt_b;
    send_str("@00000010 DEADBEEF\n", 0);
    tests_run++; if (wr_cnt_a - c0 !== 1) begin tests_failed++; $display("FAIL basic_writes: got %0d required 1", wr_cnt_a - c0); end
    tests_run++; if (last_addr_a !== 11'd4) begin tests_failed++; $display("FAIL basic_addr: got %0h required 4", last_addr_a); end
    tests_run++; if (last_data_a !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL basic_data: got %h required deadbeef", last_data_a); end
    tests_run++; if (last_be_a !== 4'hF) begin tests_failed++; $display("FAIL basic_be: got %h required f", last_be_a); end
    tests_run++; if (word_a !== 16'd1 || line_a !== 16'd1) begin tests_failed++; $display("FAIL basic_counts: got word=%0d line=%0d required 1 1", word_a, line_a); end
    tests_run++; if (err_a !== 1'b0 || busy_a !== 1'b0) begin tests_failed++; $display("FAIL basic_err_busy: got %b%b required 00", err_a, busy_a); end
    tests_run++; if (wr_cnt_b - d0 !== 1 || last_addr_b !== 11'd1 || last_be_b !== 16'h000F) begin tests_failed++; $display("FAIL basic_w128: got n=%0d addr=%0h be=%h required 1 1 000f", wr_cnt_b - d0, last_addr_b, last_be_b); end
    tests_run++; if (last_data_b !== {4{32'hDEADBEEF}}) begin tests_failed++; $display("FAIL basic_w128_data: got %h required deadbeef x4", last_data_b); end
    $display("[TB] test_basic done");
  endtask

  task automatic test_wide();
    do_reset();
    send_str("@0000001C 12345678\n", 0);
    tests_run++; if (last_addr_b !== 11'd1) begin tests_failed++; $display("FAIL wide_addr: got %0h required 1", last_addr_b); end
    tests_run++; if (last_be_b !== 16'hF000) begin tests_failed++; $display("FAIL wide_be: got %h required f000", last_be_b); end
    tests_run++; if (last_data_b[127:96] !== 32'h12345678) begin tests_failed++; $display("FAIL wide_data: got %h required 12345678", last_data_b[127:96]); end
    tests_run++; if (last_addr_a !== 11'd7) begin tests_failed++; $display("FAIL wide_addr32: got %0h required 7", last_addr_a); end
    $display("[TB] test_wide done");
  endtask

  task automatic test_gappy();
    int c0;
    do_reset(); c0 = wr_cnt_a;
    send_str("// hdr\n\n@00000000 0000000A // x\n", 1);
    tests_run++; if (wr_cnt_a - c0 !== 1) begin tests_failed++; $display("FAIL gappy_writes: got %0d required 1", wr_cnt_a - c0); end
    tests_run++; if (last_data_a !== 32'h0000000A || last_addr_a !== 11'd0) begin tests_failed++; $display("FAIL gappy_word: got %0h@%0h required a@0", last_data_a, last_addr_a); end
    tests_run++; if (line_a !== 16'd3) begin tests_failed++; $display("FAIL gappy_lines: got %0d required 3", line_a); end
    tests_run++; if (err_a !== 1'b0) begin tests_failed++; $display("FAIL gappy_err: got %b required 0", err_a); end
    $display("[TB] test_gappy done");
  endtask

  task automatic test_bad_lines();
    int c0;
    do_reset(); c0 = wr_cnt_a;
    send_str("@0000001 11111111\n@00000002 22222222\n", 0);
    tests_run++; if (wr_cnt_a - c0 !== 0) begin tests_failed++; $display("FAIL bad_nowrite: got %0d required 0", wr_cnt_a - c0); end
    tests_run++; if (err_a !== 1'b1) begin tests_failed++; $display("FAIL bad_err: got %b required 1", err_a); end
    send_str("@00000004 33333333\n", 0);
    tests_run++; if (wr_cnt_a - c0 !== 1 || last_addr_a !== 11'd1 || last_data_a !== 32'h33333333) begin tests_failed++; $display("FAIL bad_recover: got n=%0d %h@%0h required 1 33333333@1", wr_cnt_a - c0, last_data_a, last_addr_a); end
    tests_run++; if (line_a !== 16'd3 || word_a !== 16'd1) begin tests_failed++; $display("FAIL bad_counts: got line=%0d word=%0d required 3 1", line_a, word_a); end
    tests_run++; if (last_addr_b !== 11'd0 || last_be_b !== 16'h00F0) begin tests_failed++; $display("FAIL bad_w128: got %0h be=%h required 0 00f0", last_addr_b, last_be_b); end
    $display("[TB] test_bad_lines done");
  endtask

  task automatic test_nl_and_cr();
    int c0;
    do_reset(); c0 = wr_cnt_a;
    send_str("@000000\n", 0);
    tests_run++; if (err_a !== 1'b1 || line_a !== 16'd1 || busy_a !== 1'b0) begin tests_failed++; $display("FAIL nl_abort: got err=%b line=%0d busy=%b required 1 1 0", err_a, line_a, busy_a); end
    send_str("@00000008", 0);
    send_byte(8'h0D, 0);
    send_str(" 00000005", 0);
    send_byte(8'h0D, 0);
    send_str("\n", 0);
    tests_run++; if (wr_cnt_a - c0 !== 1 || last_addr_a !== 11'd2 || last_data_a !== 32'd5) begin tests_failed++; $display("FAIL cr_ignored: got n=%0d %h@%0h required 1 5@2", wr_cnt_a - c0, last_data_a, last_addr_a); end
    tests_run++; if (line_a !== 16'd2) begin tests_failed++; $display("FAIL cr_lines: got %0d required 2", line_a); end
    $display("[TB] test_nl_and_cr done");
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset(); c0 = wr_cnt_a;
    send_str("@00000020 AAAAAAAA\n@00000024 BBBBBBBB\n", 0);
    tests_run++; if (wr_cnt_a - c0 !== 2 || word_a !== 16'd2) begin tests_failed++; $display("FAIL b2b_writes: got n=%0d word=%0d required 2 2", wr_cnt_a - c0, word_a); end
    tests_run++; if (last_addr_a !== 11'd9 || last_data_a !== 32'hBBBBBBBB) begin tests_failed++; $display("FAIL b2b_last: got %h@%0h required bbbbbbbb@9", last_data_a, last_addr_a); end
    tests_run++; if (last_addr_b !== 11'd2 || last_be_b !== 16'h00F0) begin tests_failed++; $display("FAIL b2b_w128: got %0h be=%h required 2 00f0", last_addr_b, last_be_b); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_done();
    int c0;
    do_reset();
    send_str("@00000000 00000001\n", 0);
    c0 = wr_cnt_a;
    send_byte(8'h04, 0);
    rx_valid = 1'b0;
    tests_run++; if (done_a !== 1'b1 || rdy_a !== 1'b0 || busy_a !== 1'b0) begin tests_failed++; $display("FAIL done_state: got done=%b ready=%b busy=%b required 1 0 0", done_a, rdy_a, busy_a); end
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin rx_data = (i % 2 == 0) ? 8'h40 : 8'h0A; @(posedge clk); #1; end
    rx_valid = 1'b0;
    tests_run++; if (wr_cnt_a - c0 !== 0 || word_a !== 16'd1 || line_a !== 16'd1) begin tests_failed++; $display("FAIL done_ignores: got n=%0d word=%0d line=%0d required 0 1 1", wr_cnt_a - c0, word_a, line_a); end
    tests_run++; if (done_a !== 1'b1 || err_a !== 1'b0) begin tests_failed++; $display("FAIL done_sticky: got done=%b err=%b required 1 0", done_a, err_a); end
    $display("[TB] test_done done");
  endtask

  task automatic test_reset_mid();
    int c0;
    do_reset();
    send_str("\n@00000008 11111111\n@00000000 1234", 0);
    c0 = wr_cnt_a;
    tests_run++; if (busy_a !== 1'b1 || line_a !== 16'd2 || wr_addr_a !== 11'd2) begin tests_failed++; $display("FAIL mid_pre: got busy=%b line=%0d addr=%0h required 1 2 2", busy_a, line_a, wr_addr_a); end
    rst_n = 1'b0; #1;
    tests_run++; if ({busy_a, done_a, err_a, wr_en_a} !== 4'b0 || rdy_a !== 1'b1) begin tests_failed++; $display("FAIL mid_flags: got bdew=%b ready=%b required 0000 1", {busy_a, done_a, err_a, wr_en_a}, rdy_a); end
    tests_run++; if ({line_a, word_a, wr_addr_a, wr_data_a, wr_be_a} !== '0) begin tests_failed++; $display("FAIL mid_clear: got %h required 0", {line_a, word_a, wr_addr_a, wr_data_a, wr_be_a}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tests_run++; if (wr_cnt_a - c0 !== 0) begin tests_failed++; $display("FAIL mid_nowrite: got %0d required 0", wr_cnt_a - c0); end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_checksum();
    do_reset();
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_str("@00000000 00000001\n@00000004 FFFFFFFF\n#00000000\n", 0);
    tests_run++; if (csum_a !== 32'd0 || csum_ok_a !== 1'b1 || err_a !== 1'b0) begin tests_failed++; $display("FAIL csum_match: got sum=%h ok=%b err=%b required 0 1 0", csum_a, csum_ok_a, err_a); end
    send_str("#00000001\n", 0);
    tests_run++; if (err_a !== 1'b1 || csum_ok_a !== 1'b1) begin tests_failed++; $display("FAIL csum_mismatch: got err=%b ok=%b required 1 1", err_a, csum_ok_a); end
`else
    send_str("#00000000\n", 0);
    tests_run++; if (err_a !== 1'b1 || line_a !== 16'd1 || word_a !== 16'd0) begin tests_failed++; $display("FAIL hash_rejected: got err=%b line=%0d word=%0d required 1 1 0", err_a, line_a, word_a); end
`endif
    $display("[TB] test_checksum done");
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    test_reset();
    test_basic();
    test_wide();
    test_gappy();
    test_bad_lines();
    test_nl_and_cr();
    test_back_to_back();
    test_done();
    test_reset_mid();
    test_checksum();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
